// File: rtl/pc_fetch_pkg.sv
// Shared defines for the fetch slice: FSM encoding, reset constants,
// boot vectors and the MIPS opcode/function fields seen by decode.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic        RST_ACT        = 1'b0;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0040_0004;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_hold_buf.sv
// One-entry pc/instr skid buffer used while the hazard unit stalls IF.
// clear wins over load, load wins over drain.
module pc_hold_buf
  import pc_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        vld_q;
  logic [31:0] pc_q;
  logic [31:0] ins_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ACT || clear_i) begin
      vld_q <= 1'b0;
      pc_q  <= '0;
      ins_q <= '0;
    end else if (load_i) begin
      vld_q <= 1'b1;
      pc_q  <= pc_i;
      ins_q <= instr_i;
    end else if (drain_i) begin
      vld_q <= 1'b0;
    end
  end

  assign valid_o = vld_q;
  assign pc_o    = pc_q;
  assign instr_o = ins_q;

endmodule

// File: rtl/pc_fetch.sv
// IF stage: PC sequencing, single-outstanding imem fetch, IF/ID register.
// Define DELAY_SLOT_EN to deliver the instruction after a branch.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        is_branch,
  input  logic [31:0] branch_target,
  input  logic        exception,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

`ifdef DELAY_SLOT_EN
  localparam bit DS_EN = 1'b1;
`else
  localparam bit DS_EN = 1'b0;
`endif

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         vld_q, vld_d;
  logic [31:0]  ifpc_q, ifpc_d;
  logic [31:0]  ins_q, ins_d;
  logic         pend_q, pend_d;
  logic [31:0]  ptgt_q, ptgt_d;

  logic         buf_load, buf_drain, buf_clr;
  logic         buf_vld;
  logic [31:0]  buf_pc, buf_ins;
  logic         br_now;
  logic [31:0]  br_tgt;

  pc_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .clear_i (buf_clr),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .valid_o (buf_vld),
    .pc_o    (buf_pc),
    .instr_o (buf_ins)
  );

  // A fresh branch overrides one still pending from a stall.
  assign br_now = is_branch | pend_q;
  assign br_tgt = is_branch ? word_align(branch_target) : ptgt_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    vld_d     = vld_q;
    ifpc_d    = ifpc_q;
    ins_d     = ins_q;
    pend_d    = pend_q;
    ptgt_d    = ptgt_q;
    buf_load  = 1'b0;
    buf_drain = 1'b0;
    buf_clr   = 1'b0;
    imem_req  = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (stall) begin
          if (is_branch) begin
            pend_d = 1'b1;
            ptgt_d = word_align(branch_target);
          end
          if (imem_ready) begin
            buf_load = 1'b1;
            state_d  = ST_HOLD;
          end
        end else if (br_now) begin
          pend_d = 1'b0;
          if (DS_EN && imem_ready) begin
            vld_d  = 1'b1;
            ifpc_d = pc_q;
            ins_d  = imem_rdata;
            pc_d   = br_tgt;
          end else if (DS_EN) begin
            vld_d  = 1'b0;
            pend_d = 1'b1;
            ptgt_d = br_tgt;
          end else begin
            vld_d = 1'b0;
            pc_d  = br_tgt;
            if (!imem_ready) state_d = ST_DRAIN;
          end
        end else if (imem_ready) begin
          vld_d  = 1'b1;
          ifpc_d = pc_q;
          ins_d  = imem_rdata;
          pc_d   = pc_q + 32'd4;
        end else begin
          vld_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (stall) begin
          if (is_branch) begin
            pend_d = 1'b1;
            ptgt_d = word_align(branch_target);
          end
        end else begin
          buf_drain = 1'b1;
          pend_d    = 1'b0;
          state_d   = ST_FETCH;
          if (br_now && !DS_EN) begin
            vld_d = 1'b0;
            pc_d  = br_tgt;
          end else begin
            vld_d  = buf_vld;
            ifpc_d = buf_pc;
            ins_d  = buf_ins;
            pc_d   = br_now ? br_tgt : pc_q + 32'd4;
          end
        end
      end
      ST_DRAIN: begin
        if (!stall) vld_d = 1'b0;
        if (is_branch) pc_d = word_align(branch_target);
        if (imem_ready) state_d = ST_FETCH;
      end
      default: state_d = ST_BOOT;
    endcase
    // Exceptions ignore stall and flush everything in flight.
    if (exception) begin
      pc_d      = word_align(EXC_VECTOR);
      vld_d     = 1'b0;
      pend_d    = 1'b0;
      buf_clr   = 1'b1;
      buf_load  = 1'b0;
      buf_drain = 1'b0;
      if ((state_q == ST_FETCH || state_q == ST_DRAIN) && !imem_ready)
        state_d = ST_DRAIN;
      else
        state_d = ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      state_q <= ST_BOOT;
      pc_q    <= word_align(RESET_PC);
      vld_q   <= 1'b0;
      ifpc_q  <= '0;
      ins_q   <= '0;
      pend_q  <= 1'b0;
      ptgt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      ifpc_q  <= ifpc_d;
      ins_q   <= ins_d;
      pend_q  <= pend_d;
      ptgt_q  <= ptgt_d;
    end
  end

  assign imem_addr = word_align(pc_q);
  assign if_valid  = vld_q;
  assign if_pc     = ifpc_q;
  assign if_instr  = ins_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch; imem returns addr ^ KEY as the word.
// Follows DELAY_SLOT_EN the same way the RTL build does.
module tb_pc_fetch;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        is_branch;
  logic [31:0] branch_target;
  logic        exception;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  pc_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .is_branch     (is_branch),
    .branch_target (branch_target),
    .exception     (exception),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ KEY;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc);
    chk({tag, ".vld"}, {31'd0, if_valid}, 32'd1);
    chk({tag, ".pc"}, if_pc, pc);
    chk({tag, ".ins"}, if_instr, pc ^ KEY);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".vld"}, {31'd0, if_valid}, 32'd0);
  endtask

  task automatic chk_req(input string tag, input logic r,
                         input logic [31:0] a);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, r});
    chk({tag, ".addr"}, imem_addr, a);
  endtask

  task automatic chk_reset(input string tag);
    chk_bubble(tag);
    chk({tag, ".pc"}, if_pc, 32'h0);
    chk({tag, ".ins"}, if_instr, 32'h0);
    chk_req(tag, 1'b0, 32'h0040_0000);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; is_branch = 1'b0;
    branch_target = '0; exception = 1'b0; imem_ready = 1'b0;
    step();
    step();
    chk_reset("rst");

    // sequential fetch, ready held high (also while in BOOT)
    rst = 1'b1; imem_ready = 1'b1;
    step();
    chk_bubble("boot");
    chk_req("boot", 1'b1, 32'h0040_0000);
    step(); chk_if("seq0", 32'h0040_0000);
    step(); chk_if("seq1", 32'h0040_0004);
    step(); chk_if("seq2", 32'h0040_0008);
    chk_req("seq2", 1'b1, 32'h0040_000C);

    // stall 3 cycles, response in first
    stall = 1'b1;
    step(); chk_if("st1", 32'h0040_0008);
    chk_req("st1", 1'b0, 32'h0040_000C);
    imem_ready = 1'b0;
    step(); chk_if("st2", 32'h0040_0008);
    step(); chk_if("st3", 32'h0040_0008);
    stall = 1'b0;
    step(); chk_if("st_rel", 32'h0040_000C);
    chk_req("st_rel", 1'b1, 32'h0040_0010);
    imem_ready = 1'b1;
    step(); chk_if("st_nxt", 32'h0040_0010);

    // taken branch to unaligned target
    is_branch = 1'b1; branch_target = 32'h0040_0103;
    step();
    if (DS) chk_if("br_ds", 32'h0040_0014);
    else chk_bubble("br_sq");
    chk_req("br", 1'b1, 32'h0040_0100);
    is_branch = 1'b0;
    step(); chk_if("br_tgt", 32'h0040_0100);

    // two branches under stall, last one wins
    stall = 1'b1; imem_ready = 1'b0;
    is_branch = 1'b1; branch_target = 32'h0040_0180;
    step(); chk_req("pb1", 1'b1, 32'h0040_0104);
    branch_target = 32'h0040_0200;
    step(); chk_if("pb2", 32'h0040_0100);
    is_branch = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    step();
    if (DS) chk_if("pb_ds", 32'h0040_0104);
    else chk_bubble("pb_sq");
    chk_req("pb", 1'b1, 32'h0040_0200);
    step(); chk_if("pb_tgt", 32'h0040_0200);

    // exception under stall with request outstanding
    stall = 1'b1; imem_ready = 1'b0; exception = 1'b1;
    step(); chk_bubble("exc");
    chk_req("exc", 1'b0, 32'h0040_0004);
    exception = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    step(); chk_bubble("exc_drain");
    chk_req("exc_drain", 1'b1, 32'h0040_0004);
    step(); chk_if("exc_vec", 32'h0040_0004);

    // wrap at top of address space
    is_branch = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    chk_req("wrap_br", 1'b1, 32'hFFFF_FFFC);
    is_branch = 1'b0;
    step(); chk_if("wrap", 32'hFFFF_FFFC);
    chk_req("wrap", 1'b1, 32'h0000_0000);

    // reset mid-request, stale response during BOOT
    imem_ready = 1'b0;
    step(); chk_bubble("mid");
    rst = 1'b0;
    step(); chk_reset("mid_rst");
    rst = 1'b1; imem_ready = 1'b1;
    step(); chk_bubble("mid_boot");
    chk_req("mid_boot", 1'b1, 32'h0040_0000);
    step(); chk_if("mid_fetch", 32'h0040_0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
